// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches floor calls and serves them in SCAN
// order, with per-floor travel time and a timed door dwell.
module elevator_ctrl_n #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = $clog2(FLOORS),
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir,
  output logic               moving,
  output logic               door_open,
  output logic               arrive,
  output logic [FLOORS-1:0]  pending
);

  localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYC - 1);
  localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               arrive_q, arrive_d;
  logic               moving_q, moving_d;
  logic               door_open_q, door_open_d;
  logic [FLOORS-1:0]  pending_q, pending_d;

  logic [FLOORS-1:0]  pnd;
  logic [FLOORS-1:0]  above_any;
  logic [FLOORS-1:0]  below_any;
  logic [FLOOR_W-1:0] floor_step;
  logic               ahead_at_step;

  // Requests seen this cycle: latched calls plus live buttons.
  assign pnd = pending_q | req;

  // For every possible floor, whether any call lies strictly above / below it.
  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_scan
      localparam logic [FLOORS-1:0] BELOW_M = (FLOORS'(1) << gi) - FLOORS'(1);
      localparam logic [FLOORS-1:0] ABOVE_M = ~(BELOW_M | (FLOORS'(1) << gi));
      assign below_any[gi] = |(pnd & BELOW_M);
      assign above_any[gi] = |(pnd & ABOVE_M);
    end
  endgenerate

  // The floor reached by the step in progress, and whether the sweep continues there.
  assign floor_step    = dir_q ? (floor_q - 1'b1) : (floor_q + 1'b1);
  assign ahead_at_step = dir_q ? below_any[floor_step] : above_any[floor_step];

  // Next-state logic: SCAN decisions in IDLE, stepping in MOVE, dwell in DOOR.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    arrive_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pnd[floor_q]) begin
          state_d = S_DOOR;
          timer_d = DOOR_LD;
        end else if (above_any[floor_q] || below_any[floor_q]) begin
          // Keep heading the same way while calls lie ahead, else reverse.
          dir_d   = dir_q ? below_any[floor_q] : ~above_any[floor_q];
          state_d = S_MOVE;
          timer_d = TRAVEL_LD;
        end
      end
      S_MOVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          floor_d  = floor_step;
          arrive_d = 1'b1;
          if (pnd[floor_step]) begin
            state_d = S_DOOR;
            timer_d = DOOR_LD;
          end else if (ahead_at_step) begin
            timer_d = TRAVEL_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        // A fresh call for this floor keeps the door open for a full dwell.
        if (req[floor_q]) begin
          timer_d = DOOR_LD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // The floor being served is cleared on door entry and stays clear while open.
    pending_d = pnd;
    if (state_d == S_DOOR) begin
      pending_d[floor_d] = 1'b0;
    end
    moving_d    = (state_d == S_MOVE);
    door_open_d = (state_d == S_DOOR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      floor_q     <= '0;
      dir_q       <= 1'b0;
      timer_q     <= '0;
      arrive_q    <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      arrive_q    <= arrive_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      pending_q   <= pending_d;
    end
  end

  assign floor     = floor_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign arrive    = arrive_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Testbench for elevator_ctrl_n: directed scenarios plus random calls, checked
// against a cycle-level behavioural model of the SCAN elevator.
module tb_elevator_ctrl_n;

  localparam int FLOORS     = 8;
  localparam int FW         = 3;
  localparam int TRAVEL_CYC = 4;
  localparam int DOOR_CYC   = 3;
  localparam int IDLE = 0, MOVING = 1, OPEN = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLOORS-1:0] req = '0;
  logic [FW-1:0]     floor;
  logic              dir, moving, door_open, arrive;
  logic [FLOORS-1:0] pending;

  int total = 0;
  int bad   = 0;

  elevator_ctrl_n #(
    .FLOORS(FLOORS), .FLOOR_W(FW), .TRAVEL_CYC(TRAVEL_CYC), .DOOR_CYC(DOOR_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .floor(floor), .dir(dir),
    .moving(moving), .door_open(door_open), .arrive(arrive), .pending(pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer floor, "down" flag, mode, cycles left in phase.
  int              m_floor;
  bit              m_down;
  int              m_mode;
  int              m_cnt;
  bit [FLOORS-1:0] m_pend;
  bit              m_arrive;

  function automatic bit calls_above(bit [FLOORS-1:0] p, int f);
    for (int i = f + 1; i < FLOORS; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_below(bit [FLOORS-1:0] p, int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_down = 0; m_mode = IDLE; m_cnt = 0; m_pend = '0; m_arrive = 0;
  endtask

  task automatic model_step(input logic [FLOORS-1:0] r);
    bit [FLOORS-1:0] p;
    int nmode, nf;
    p = m_pend | r;
    nmode = m_mode;
    nf = m_floor;
    m_arrive = 0;
    if (m_mode == IDLE) begin
      if (p[m_floor]) begin
        nmode = OPEN; m_cnt = DOOR_CYC;
      end else if (calls_above(p, m_floor) || calls_below(p, m_floor)) begin
        if (m_down) m_down = calls_below(p, m_floor);
        else        m_down = !calls_above(p, m_floor);
        nmode = MOVING; m_cnt = TRAVEL_CYC;
      end
    end else if (m_mode == MOVING) begin
      m_cnt--;
      if (m_cnt == 0) begin
        nf = m_down ? m_floor - 1 : m_floor + 1;
        m_arrive = 1;
        if (p[nf]) begin
          nmode = OPEN; m_cnt = DOOR_CYC;
        end else if (m_down ? calls_below(p, nf) : calls_above(p, nf)) begin
          m_cnt = TRAVEL_CYC;
        end else begin
          nmode = IDLE;
        end
      end
    end else begin
      if (r[m_floor]) m_cnt = DOOR_CYC;
      else begin
        m_cnt--;
        if (m_cnt == 0) nmode = IDLE;
      end
    end
    m_pend = p;
    if (nmode == OPEN) m_pend[nf] = 1'b0;
    m_floor = nf;
    m_mode = nmode;
  endtask

  function automatic logic [FW+4+FLOORS-1:0] model_vec();
    return {FW'(m_floor), m_down, m_mode == MOVING, m_mode == OPEN, m_arrive, m_pend};
  endfunction

  function automatic logic [FW+4+FLOORS-1:0] dut_vec();
    return {floor, dir, moving, door_open, arrive, pending};
  endfunction

  function automatic bit quiet();
    return (m_mode == IDLE) && (m_pend == '0);
  endfunction

  // One clock edge with the given call pulse, model advanced in lockstep.
  task automatic tick(input logic [FLOORS-1:0] r);
    req = r;
    if (rst) model_reset();
    else     model_step(r);
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick('0);
    tick('0);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL reset_values got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick('0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_single_trip();
    int arrives = 0, doors = 0;
    tick(8'h20);
    total++;
    if (moving !== 1'b1) begin
      bad++; $display("FAIL trip_start moving got=%b exp=1", moving);
    end
    for (int c = 1; c <= 40; c++) begin
      tick('0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL trip cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
      if (arrive === 1'b1) arrives++;
      if (door_open === 1'b1) doors++;
      if (c == 20) begin
        total++;
        if (floor !== 3'd5 || door_open !== 1'b1) begin
          bad++; $display("FAIL trip_at5 floor=%0d door=%b exp floor=5 door=1", floor, door_open);
        end
      end
    end
    total++;
    if (arrives != 5 || doors != DOOR_CYC || pending[5] !== 1'b0 || moving !== 1'b0) begin
      bad++; $display("FAIL trip_summary arrives=%0d doors=%0d pend5=%b exp 5 3 0", arrives, doors, pending[5]);
    end
  endtask

  task automatic test_scan_reverse();
    int stops[$];
    bit prev_door = 0;
    bit done = 0;
    total++;
    if (floor !== 3'd5 || dir !== 1'b0) begin
      bad++; $display("FAIL scan_start floor=%0d dir=%b exp 5 0", floor, dir);
    end
    tick(8'h84);
    for (int c = 0; c < 200 && !done; c++) begin
      tick('0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL scan cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
      if (door_open === 1'b1 && !prev_door) stops.push_back(int'(floor));
      prev_door = door_open;
      done = quiet();
    end
    total++;
    if (!done || stops.size() != 2 || stops[0] != 7 || stops[1] != 2) begin
      bad++; $display("FAIL scan_order done=%b stops=%p exp {7,2}", done, stops);
    end
  endtask

  task automatic test_midtrip_calls();
    int stops[$];
    bit prev_door = 0;
    bit done = 0, sent3 = 0, sent1 = 0;
    logic [FLOORS-1:0] r;
    tick(8'h01);
    for (int c = 0; c < 200 && !quiet(); c++) begin
      tick('0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL mid_home cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    tick(8'h40);
    for (int c = 0; c < 300 && !done; c++) begin
      r = '0;
      if (!sent3 && m_floor == 1) begin r = 8'h08; sent3 = 1; end
      if (!sent1 && m_floor == 3 && m_mode == OPEN) begin r = 8'h02; sent1 = 1; end
      tick(r);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL mid cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
      if (door_open === 1'b1 && !prev_door) stops.push_back(int'(floor));
      prev_door = door_open;
      done = sent1 && quiet();
    end
    total++;
    if (!done || stops.size() != 3 || stops[0] != 3 || stops[1] != 6 || stops[2] != 1) begin
      bad++; $display("FAIL mid_order done=%b stops=%p exp {3,6,1}", done, stops);
    end
  endtask

  task automatic test_door_extend();
    int doors = 0;
    bit moved = 0;
    tick(8'h04);
    for (int c = 0; c < 100 && !quiet(); c++) tick('0);
    total++;
    if (floor !== 3'd2 || door_open !== 1'b0) begin
      bad++; $display("FAIL ext_start floor=%0d door=%b exp 2 0", floor, door_open);
    end
    tick(8'h04);
    total++;
    if (door_open !== 1'b1 || moving !== 1'b0) begin
      bad++; $display("FAIL ext_open door=%b moving=%b exp 1 0", door_open, moving);
    end
    doors = 1;
    for (int c = 1; c < 12; c++) begin
      tick(c == 2 ? 8'h04 : 8'h00);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL ext cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
      if (door_open === 1'b1) doors++;
      if (moving === 1'b1 || floor !== 3'd2) moved = 1;
    end
    total++;
    if (doors != 2 + DOOR_CYC || moved) begin
      bad++; $display("FAIL ext_len doors=%0d moved=%b exp 5 0", doors, moved);
    end
  endtask

  task automatic test_reset_midtravel();
    tick(8'h40);
    for (int c = 0; c < 100 && !(m_floor == 3 && m_mode == MOVING); c++) tick('0);
    tick('0);
    total++;
    if (dut_vec() !== model_vec() || moving !== 1'b1 || pending[6] !== 1'b1 || floor !== 3'd3) begin
      bad++; $display("FAIL rmid_pre got=%h exp=%h", dut_vec(), model_vec());
    end
    rst = 1'b1;
    tick('0);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL rmid_reset got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick('0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL rmid_after cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [FLOORS-1:0] r;
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      if ($urandom_range(0, 9) == 0) r = FLOORS'(1) << $urandom_range(0, FLOORS - 1);
      if ($urandom_range(0, 49) == 0) r = FLOORS'($urandom);
      tick(r);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL random cyc=%0d req=%h got=%h exp=%h", c, r, dut_vec(), model_vec());
      end
      total++;
      if (moving === 1'b1 && door_open === 1'b1) begin
        bad++; $display("FAIL random_excl cyc=%0d moving=1 door=1 exp not both", c);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_trip();
    test_scan_reverse();
    test_midtrip_calls();
    test_door_extend();
    test_reset_midtravel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
